// File: rtl/elbeth_mem_arbiter.sv
// Arbitrates the instruction and data ports onto one single-port SRAM with a fixed read latency.
// Define ELBETH_ARB_RR_EN for round-robin arbitration; otherwise dmem has fixed priority over imem.
module elbeth_mem_arbiter #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned AW        = 12
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          imem_en,
    input  logic [AW-1:0] imem_addr,
    input  logic [3:0]    imem_rw,
    input  logic [31:0]   imem_wdata,
    output logic [31:0]   imem_rdata,
    output logic          imem_ready,
    output logic          imem_error,

    input  logic          dmem_en,
    input  logic [AW-1:0] dmem_addr,
    input  logic [3:0]    dmem_rw,
    input  logic [31:0]   dmem_wdata,
    output logic [31:0]   dmem_rdata,
    output logic          dmem_ready,
    output logic          dmem_error,

    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-3:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t        state;
    port_t         grant;
    logic [1:0]    cnt;

    logic          pick_d;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_rw;
    logic [31:0]   req_wdata;
    logic          req_bad;

    // grant doubles as the last-grant pointer: it changes only on a new grant
    always_comb begin
`ifdef ELBETH_ARB_RR_EN
        pick_d    = dmem_en & (~imem_en | (grant == PORT_I));
`else
        pick_d    = dmem_en;
`endif
        req_addr  = pick_d ? dmem_addr  : imem_addr;
        req_rw    = pick_d ? dmem_rw    : imem_rw;
        req_wdata = pick_d ? dmem_wdata : imem_wdata;
        req_bad   = 32'(req_addr) >= MEM_BYTES;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= PORT_I;
            cnt        <= '0;
            imem_rdata <= '0;
            imem_ready <= 1'b0;
            imem_error <= 1'b0;
            dmem_rdata <= '0;
            dmem_ready <= 1'b0;
            dmem_error <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imem_en || dmem_en) begin
                        grant <= pick_d ? PORT_D : PORT_I;
                        if (req_bad) begin
                            // out-of-range: answer directly, SRAM untouched
                            state <= RESP;
                            if (pick_d) begin
                                dmem_rdata <= '0;
                                dmem_ready <= 1'b1;
                                dmem_error <= 1'b1;
                            end else begin
                                imem_rdata <= '0;
                                imem_ready <= 1'b1;
                                imem_error <= 1'b1;
                            end
                        end else begin
                            state      <= ISSUE;
                            sram_en    <= 1'b1;
                            sram_we    <= req_rw;
                            sram_addr  <= req_addr[AW-1:2];
                            sram_wdata <= req_wdata;
                        end
                    end
                end
                ISSUE: begin
                    sram_en <= 1'b0;
                    sram_we <= '0;
                    cnt     <= 2'(READ_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state <= RESP;
                        if (grant == PORT_D) begin
                            dmem_rdata <= sram_rdata;
                            dmem_ready <= 1'b1;
                            dmem_error <= 1'b0;
                        end else begin
                            imem_rdata <= sram_rdata;
                            imem_ready <= 1'b1;
                            imem_error <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    imem_ready <= 1'b0;
                    imem_error <= 1'b0;
                    dmem_ready <= 1'b0;
                    dmem_error <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed scoreboard bench for elbeth_mem_arbiter with a behavioural SRAM (READ_LAT=2, MEM_BYTES=2048).
module tb_elbeth_mem_arbiter;

  localparam int unsigned RL   = 2;
  localparam int unsigned MEMB = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_en = 1'b0, dmem_en = 1'b0;
  logic [11:0] imem_addr = '0, dmem_addr = '0;
  logic [3:0]  imem_rw = '0, dmem_rw = '0;
  logic [31:0] imem_wdata = '0, dmem_wdata = '0;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        imem_ready, imem_error, dmem_ready, dmem_error;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int errors = 0;
  int checks = 0;
  int ready_events = 0;
  int sram_hits = 0;

  typedef struct packed {
    logic        port;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [1024];
  logic [31:0] mem [1024];
  logic [31:0] pipe [RL];
  bit          mem_loaded = 1'b0;

  always #5 clk = ~clk;

  elbeth_mem_arbiter #(.MEM_BYTES(MEMB), .READ_LAT(RL), .AW(12)) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rw(imem_rw), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_rw(dmem_rw), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic check(input bit ok, input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i == 4) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int unsigned i = 0; i < 1024; i++) mem[i] <= init_word(i);
      for (int unsigned k = 0; k < RL; k++) pipe[k] <= '0;
      mem_loaded <= 1'b1;
    end else begin
      if (sram_en) begin
        sram_hits <= sram_hits + 1;
        pipe[0] <= mem[sram_addr];
        for (int unsigned b = 0; b < 4; b++)
          if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      for (int unsigned k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign sram_rdata = pipe[RL-1];

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] rd;
    logic        er;
    if (rst && (imem_ready || dmem_ready)) begin
      ready_events++;
      check((imem_ready & dmem_ready) === 1'b0, "ready_overlap", imem_ready & dmem_ready, 1'b0);
      check((sb.size() > 0) === 1'b1, "ready_expected", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        er = e.port ? dmem_error : imem_error;
        rd = e.port ? dmem_rdata : imem_rdata;
        check(dmem_ready === e.port, "grant_port", dmem_ready, e.port);
        check(er === e.err, "error_flag", er, e.err);
        if (e.chk) check(rd === e.data, "rdata", rd, e.data);
      end
    end
  end

  task automatic push_exp(input logic port, input logic [11:0] a, input logic [3:0] rw,
                          input logic [31:0] wd);
    exp_t e;
    logic [31:0] w;
    e.port = port;
    if (32'(a) >= MEMB) begin
      e.err = 1'b1; e.chk = 1'b1; e.data = '0;
    end else begin
      e.err = 1'b0;
      w = ref_mem[a[11:2]];
      if (rw == 4'b0000) begin
        e.chk = 1'b1; e.data = w;
      end else begin
        for (int unsigned b = 0; b < 4; b++) if (rw[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[a[11:2]] = w;
        e.chk = 1'b0; e.data = '0;
      end
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic port, input logic [11:0] a, input logic [3:0] rw,
                       input logic [31:0] wd);
    push_exp(port, a, rw, wd);
    if (port) begin
      dmem_en = 1'b1; dmem_addr = a; dmem_rw = rw; dmem_wdata = wd;
    end else begin
      imem_en = 1'b1; imem_addr = a; imem_rw = rw; imem_wdata = wd;
    end
  endtask

  task automatic wait_ready(input int exp_lat, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_ready || dmem_ready) && n < 20);
    check(n == exp_lat, tag, n, exp_lat);
  endtask

  task automatic check_issue(input logic [3:0] rw, input logic [9:0] wa, input logic [31:0] wd);
    @(negedge clk);
    check(sram_en === 1'b1, "issue_en", sram_en, 1'b1);
    check(sram_we === rw, "issue_we", sram_we, rw);
    check(sram_addr === wa, "issue_addr", sram_addr, wa);
    if (rw != 4'b0000) check(sram_wdata === wd, "issue_wdata", sram_wdata, wd);
  endtask

  initial begin
    int hits0;
    int ev0;
    logic [117:0] outs;

    for (int unsigned i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    outs = {imem_rdata, imem_ready, imem_error, dmem_rdata, dmem_ready,
            dmem_error, sram_en, sram_we, sram_addr, sram_wdata};
    check(outs === 118'd0, "reset_outputs", outs, 0);
    rst = 1'b1;

    @(negedge clk);
    drive(1'b1, 12'h010, 4'b0000, 32'h0);
    check_issue(4'b0000, 10'd4, 32'h0);
    wait_ready(RL + 1, "dmem_read_lat");
    dmem_en = 1'b0;

    @(negedge clk);
    drive(1'b1, 12'h020, 4'b0010, 32'h0000AB00);
    check_issue(4'b0010, 10'd8, 32'h0000AB00);
    wait_ready(RL + 1, "byte_write_lat");
    dmem_en = 1'b0;
    @(negedge clk);
    drive(1'b1, 12'h020, 4'b0000, 32'h0);
    wait_ready(RL + 2, "byte_readback_lat");
    dmem_en = 1'b0;
    check(dmem_rdata === 32'hC0DEAB08, "byte_readback_word", dmem_rdata, 32'hC0DEAB08);

    @(negedge clk);
`ifdef ELBETH_ARB_RR_EN
    drive(1'b0, 12'h040, 4'b0000, 32'h0);
    drive(1'b1, 12'h044, 4'b0000, 32'h0);
`else
    drive(1'b1, 12'h044, 4'b0000, 32'h0);
    drive(1'b0, 12'h040, 4'b0000, 32'h0);
`endif
    wait_ready(RL + 2, "both_first_lat");
    if (dmem_ready) dmem_en = 1'b0;
    else imem_en = 1'b0;
    wait_ready(RL + 3, "both_second_lat");
    imem_en = 1'b0;
    dmem_en = 1'b0;

    @(negedge clk);
    drive(1'b0, 12'h7FC, 4'b0000, 32'h0);
    wait_ready(RL + 2, "top_word_lat");
    imem_en = 1'b0;
    @(negedge clk);
    hits0 = sram_hits;
    drive(1'b0, 12'h800, 4'b0000, 32'h0);
    wait_ready(1, "oor_read_lat");
    check(sram_en === 1'b0, "oor_read_sram_en", sram_en, 1'b0);
    imem_en = 1'b0;
    @(negedge clk);
    drive(1'b1, 12'hFFC, 4'b1111, 32'h12345678);
    wait_ready(1, "oor_write_lat");
    dmem_en = 1'b0;
    repeat (2) @(negedge clk);
    check(sram_hits == hits0, "oor_no_sram_access", sram_hits, hits0);

    @(negedge clk);
    dmem_en = 1'b1; dmem_addr = 12'h030; dmem_rw = 4'b0000; dmem_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    ev0 = ready_events;
    rst = 1'b0;
    #1;
    outs = {imem_rdata, imem_ready, imem_error, dmem_rdata, dmem_ready,
            dmem_error, sram_en, sram_we, sram_addr, sram_wdata};
    check(outs === 118'd0, "abort_outputs", outs, 0);
    dmem_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check(ready_events == ev0, "abort_no_ready", ready_events, ev0);
    drive(1'b1, 12'h030, 4'b0000, 32'h0);
    wait_ready(RL + 2, "post_abort_lat");
    dmem_en = 1'b0;

    @(negedge clk);
    drive(1'b1, 12'h100, 4'b0000, 32'h0);
    wait_ready(RL + 2, "b2b_first_lat");
    for (int unsigned i = 1; i < 4; i++) begin
      drive(1'b1, 12'h100 + 12'(4 * i), 4'b0000, 32'h0);
      wait_ready(RL + 3, "b2b_period");
    end
    dmem_en = 1'b0;

    repeat (3) @(negedge clk);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
